// File: rtl/psum_drain_collector.sv
// psum_drain_collector
//   Captures the bottom-row psum_out streams of the systolic array, removes
//   the one-cycle-per-column diagonal skew, and queues whole output rows in a
//   row FIFO. The FIFO drains to writeback over a valid/ready handshake.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous flush of all state, including error flags
//   col_valid       per-column sample valid (bit j = column j)
//   col_psum        per-column psum, column j at [j*PSUM_WIDTH +: PSUM_WIDTH]
//   rows_total      rows in the current layer (0 = unbounded)
//   array_hold      asks the array controller to stall process_en
//   out_valid/out_ready/out_data/out_last   row output handshake
//   done            one-cycle pulse after the last row is accepted
//   skew_err        sticky, misaligned wavefront seen
//   overflow_err    sticky, a row was dropped on a full FIFO
module psum_drain_collector #(
    parameter int NUM_COL       = 4,
    parameter int PSUM_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int ROW_CNT_WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic [NUM_COL-1:0]             col_valid,
    input  logic [NUM_COL*PSUM_WIDTH-1:0]  col_psum,
    input  logic [ROW_CNT_WIDTH-1:0]       rows_total,
    output logic                           array_hold,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_COL*PSUM_WIDTH-1:0]  out_data,
    output logic                           out_last,
    output logic                           done,
    output logic                           skew_err,
    output logic                           overflow_err
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(FIFO_DEPTH);
    // Room kept free for the rows still travelling through the deskew pipe.
    localparam logic [CNT_W-1:0] HOLD_LVL = CNT_W'(FIFO_DEPTH - NUM_COL);

    typedef logic [NUM_COL-1:0][PSUM_WIDTH-1:0] row_t;
    typedef struct packed {
        logic last;
        row_t data;
    } entry_t;

    row_t               in_row;
    row_t               dly_row;
    logic [NUM_COL-1:0] dly_valid;

    assign in_row = col_psum;

    // Deskew: column j is delayed NUM_COL-1-j cycles so all columns of one
    // row line up with the (undelayed) last column.
    for (genvar j = 0; j < NUM_COL; j++) begin : g_col
        localparam int D = NUM_COL - 1 - j;
        if (D == 0) begin : g_nodly
            assign dly_valid[j] = col_valid[j];
            assign dly_row[j]   = in_row[j];
        end else begin : g_dly
            logic [D-1:0]                 vld_pipe;
            logic [D-1:0][PSUM_WIDTH-1:0] dat_pipe;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else if (clear) begin
                    vld_pipe <= '0;
                    dat_pipe <= '0;
                end else begin
                    vld_pipe[0] <= col_valid[j];
                    dat_pipe[0] <= in_row[j];
                    for (int s = 1; s < D; s++) begin
                        vld_pipe[s] <= vld_pipe[s-1];
                        dat_pipe[s] <= dat_pipe[s-1];
                    end
                end
            end
            assign dly_valid[j] = vld_pipe[D-1];
            assign dly_row[j]   = dat_pipe[D-1];
        end
    end

    logic aligned;
    logic misalign;
    assign aligned  = &dly_valid;
    assign misalign = (|dly_valid) && !aligned;

    // Row FIFO
    entry_t                     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr, rd_ptr;
    logic [CNT_W-1:0]           count;
    logic [ROW_CNT_WIDTH-1:0]   push_idx;
    entry_t                     head;
    logic                       full, pop, do_push, drop, last_tag;

    assign head     = mem[rd_ptr];
    assign full     = (count == FULL_LVL);
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign do_push  = aligned && (!full || pop);
    assign drop     = aligned && full && !pop;
    assign last_tag = (rows_total != '0) &&
                      (push_idx == rows_total - ROW_CNT_WIDTH'(1));

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            push_idx     <= '0;
            done         <= 1'b0;
            skew_err     <= 1'b0;
            overflow_err <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            push_idx     <= '0;
            done         <= 1'b0;
            skew_err     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= '{last: last_tag, data: dly_row};
                wr_ptr      <= ptr_inc(wr_ptr);
                push_idx    <= last_tag ? '0 : push_idx + ROW_CNT_WIDTH'(1);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            count <= count + {{(CNT_W-1){1'b0}}, do_push}
                           - {{(CNT_W-1){1'b0}}, pop};
            done  <= pop && head.last;
            if (misalign) skew_err     <= 1'b1;
            if (drop)     overflow_err <= 1'b1;
        end
    end

    assign out_valid  = (count != '0);
    assign out_data   = head.data;
    assign out_last   = head.last;
    assign array_hold = (count >= HOLD_LVL);

endmodule

// File: tb/tb_psum_drain_collector.sv
// Directed bench for psum_drain_collector (NUM_COL=4, PSUM_WIDTH=32,
// FIFO_DEPTH=8). Each task drives one scenario and checks inline.
// Timing model: every step is posedge + 1ns; outputs sampled then reflect the
// cycle that just began, inputs driven then are captured at the next edge.
module tb_psum_drain_collector;
    localparam int NC = 4;
    localparam int W  = 32;
    localparam int FD = 8;
    localparam int RW = 16;

    logic              clk, rst_n, clear, out_ready;
    logic [NC-1:0]     col_valid;
    logic [NC*W-1:0]   col_psum;
    logic [RW-1:0]     rows_total;
    logic              array_hold, out_valid, out_last, done, skew_err, overflow_err;
    logic [NC*W-1:0]   out_data;

    int n_cmp = 0;
    int n_bad = 0;

    psum_drain_collector #(.NUM_COL(NC), .PSUM_WIDTH(W), .FIFO_DEPTH(FD), .ROW_CNT_WIDTH(RW)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .col_valid(col_valid), .col_psum(col_psum),
        .rows_total(rows_total), .array_hold(array_hold), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .done(done),
        .skew_err(skew_err), .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Row k, column j carries k in the low half and j in the high half.
    function automatic logic [W-1:0] rowval(input int k, input int j);
        return W'(k) | (W'(j) << 16);
    endfunction

    function automatic logic [NC*W-1:0] rowvec(input int k);
        logic [NC*W-1:0] r;
        for (int j = 0; j < NC; j++) r[j*W +: W] = rowval(k, j);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Diagonal wavefront: in cycle c, column j presents row c-j of n rows.
    task automatic drive(input int c, input int n, input int base);
        for (int j = 0; j < NC; j++) begin
            col_valid[j] = (c - j >= 0) && (c - j < n);
            col_psum[j*W +: W] = col_valid[j] ? rowval(base + c - j, j) : '0;
        end
    endtask

    task automatic idle();
        col_valid = '0;
        col_psum  = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; out_ready = 1'b0; rows_total = '0;
        idle();
        #12;
        n_cmp++;
        if ({array_hold, out_valid, out_last, done, skew_err, overflow_err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags got %b want 000000",
                {array_hold, out_valid, out_last, done, skew_err, overflow_err});
        end
        n_cmp++;
        if (out_data !== '0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_row();
        logic [NC*W-1:0] exp_row;
        exp_row = {32'h103, 32'h102, 32'h101, 32'h100};
        do_clear();
        rows_total = '0; out_ready = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            n_cmp++;
            if (out_valid !== (c == 14)) begin
                n_bad++; $display("FAIL single_valid c=%0d got %b want %b", c, out_valid, (c == 14));
            end
            if (c == 14) begin
                n_cmp++;
                if (out_data !== exp_row) begin
                    n_bad++; $display("FAIL single_data got %h want %h", out_data, exp_row);
                end
            end
            for (int j = 0; j < NC; j++) begin
                col_valid[j] = (c == 10 + j);
                col_psum[j*W +: W] = W'(32'h100 + j);
            end
            step();
        end
        idle();
    endtask

    task automatic test_backpressure();
        int exp_cnt;
        do_clear();
        rows_total = RW'(6); out_ready = 1'b0;
        for (int c = 0; c <= 12; c++) begin
            exp_cnt = (c - 3 < 0) ? 0 : ((c - 3 > 6) ? 6 : c - 3);
            n_cmp++;
            if (array_hold !== (exp_cnt >= 4)) begin
                n_bad++; $display("FAIL bp_hold c=%0d got %b want %b", c, array_hold, (exp_cnt >= 4));
            end
            n_cmp++;
            if (out_valid !== (exp_cnt != 0)) begin
                n_bad++; $display("FAIL bp_valid c=%0d got %b want %b", c, out_valid, (exp_cnt != 0));
            end
            drive(c, 6, 0);
            step();
        end
        idle();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_cmp++;
            if (out_data !== rowvec(k) || out_valid !== 1'b1) begin
                n_bad++; $display("FAIL bp_row k=%0d got %h/%b want %h/1", k, out_data, out_valid, rowvec(k));
            end
            n_cmp++;
            if (out_last !== (k == 5) || done !== 1'b0) begin
                n_bad++; $display("FAIL bp_last k=%0d got last=%b done=%b want last=%b done=0",
                    k, out_last, done, (k == 5));
            end
            step();
        end
        n_cmp++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL bp_done got done=%b valid=%b want done=1 valid=0", done, out_valid);
        end
        step();
        n_cmp++;
        if (done !== 1'b0) begin n_bad++; $display("FAIL bp_done_pulse got %b want 0", done); end
        out_ready = 1'b0;
    endtask

    // Fill 8 rows, then push a 9th either with or without a same-cycle pop.
    task automatic test_full(input logic pop_on_push, input int base);
        int first;
        do_clear();
        rows_total = '0; out_ready = 1'b0;
        for (int c = 0; c <= 11; c++) begin drive(c, 8, base); step(); end
        idle();
        n_cmp++;
        if (array_hold !== 1'b1 || overflow_err !== 1'b0) begin
            n_bad++; $display("FAIL full_pre hold=%b ovf=%b want 1/0", array_hold, overflow_err);
        end
        for (int c = 0; c <= 3; c++) begin
            drive(c, 1, base + 8);
            out_ready = pop_on_push && (c == 3);
            step();
        end
        idle();
        out_ready = 1'b0;
        n_cmp++;
        if (overflow_err !== !pop_on_push) begin
            n_bad++; $display("FAIL full_ovf got %b want %b", overflow_err, !pop_on_push);
        end
        first = pop_on_push ? base + 1 : base;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== rowvec(first + k)) begin
                n_bad++; $display("FAIL full_row k=%0d got %h/%b want %h/1",
                    k, out_data, out_valid, rowvec(first + k));
            end
            step();
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL full_empty got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_skew();
        do_clear();
        rows_total = '0; out_ready = 1'b0;
        for (int c = 0; c <= 7; c++) begin
            for (int j = 0; j < NC; j++)
                col_valid[j] = (j == 2) ? (c == 3) : (c == j);
            col_psum = '0;
            step();
        end
        idle();
        n_cmp++;
        if (skew_err !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++; $display("FAIL skew_flag got err=%b valid=%b want 1/0", skew_err, out_valid);
        end
        for (int c = 0; c <= 4; c++) begin drive(c, 1, 'h77); step(); end
        idle();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== rowvec('h77) || skew_err !== 1'b1) begin
            n_bad++; $display("FAIL skew_recover got %h/%b err=%b want %h/1 err=1",
                out_data, out_valid, skew_err, rowvec('h77));
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        rows_total = '0; out_ready = 1'b0;
        for (int c = 0; c <= 6; c++) begin drive(c, 3, 'h80); step(); end
        for (int c = 0; c <= 1; c++) begin drive(c, 1, 'h90); step(); end
        idle();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== rowvec('h80)) begin
            n_bad++; $display("FAIL rmid_pre got %h/%b want %h/1", out_data, out_valid, rowvec('h80));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({array_hold, out_valid, out_last, done, skew_err, overflow_err} !== 6'b0 || out_data !== '0) begin
            n_bad++; $display("FAIL rmid_async got flags=%b data=%h want 0",
                {array_hold, out_valid, out_last, done, skew_err, overflow_err}, out_data);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (out_valid !== 1'b0 || skew_err !== 1'b0) begin
                n_bad++; $display("FAIL rmid_after i=%0d got valid=%b err=%b want 0/0", i, out_valid, skew_err);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_clear();
        rows_total = '0; out_ready = 1'b0;
        col_valid = 4'b0001;
        step();
        idle();
        for (int i = 0; i < 4; i++) step();
        for (int c = 0; c <= 6; c++) begin drive(c, 2, 'hA0); step(); end
        idle();
        n_cmp++;
        if (out_valid !== 1'b1 || skew_err !== 1'b1) begin
            n_bad++; $display("FAIL clr_pre got valid=%b err=%b want 1/1", out_valid, skew_err);
        end
        do_clear();
        n_cmp++;
        if ({array_hold, out_valid, out_last, done, skew_err, overflow_err} !== 6'b0 || out_data !== '0) begin
            n_bad++; $display("FAIL clr_flush got flags=%b data=%h want 0",
                {array_hold, out_valid, out_last, done, skew_err, overflow_err}, out_data);
        end
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_bad++; $display("FAIL clr_stay got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_backpressure();
        test_full(1'b1, 'h40);
        test_full(1'b0, 'h60);
        test_skew();
        test_reset_mid();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/psum_drain_collector.md
Name: psum_drain_collector

Overview:
- Read-side end of the systolic array's partial-sum path.
- Sits below the bottom PE row and captures each column's psum_out stream. Column j's stream lags column j-1 by exactly one cycle (diagonal wavefront).
- De-skews the streams into whole output rows and buffers them in a row FIFO.
- Hands rows to the writeback logic over a valid/ready handshake, and raises array_hold so the array controller can deassert process_en before the FIFO overflows.

Parameters:
- NUM_COL, 4, number of array columns drained.
- PSUM_WIDTH, 32, width of one psum (matches PE psum_out).
- FIFO_DEPTH, 8, row FIFO depth in rows; must be > NUM_COL.
- ROW_CNT_WIDTH, 16, width of the row counter and of rows_total.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous flush of all state, including error flags
- col_valid  input  NUM_COL  per-column sample valid; bit j is column j
- col_psum  input  NUM_COL*PSUM_WIDTH  per-column psum; bits [j*PSUM_WIDTH +: PSUM_WIDTH] are column j
- rows_total  input  ROW_CNT_WIDTH  rows in the current layer; static while busy; 0 means unbounded
- array_hold  output  1  request to the controller to stall process_en
- out_valid  output  1  out_data holds a row
- out_ready  input  1  downstream accepts
- out_data  output  NUM_COL*PSUM_WIDTH  de-skewed row; column j is in the same slice as col_psum
- out_last  output  1  out_data is row rows_total-1
- done  output  1  one-cycle pulse after the last row is accepted
- skew_err  output  1  sticky: misaligned wavefront detected
- overflow_err  output  1  sticky: row dropped because the FIFO was full

Behaviour:
- Reset (rst_n low, async): every register is cleared. All outputs are 0, FIFO empty, row counter 0.
- clear high at a clock edge has the same effect as reset, synchronously, and takes priority over every other event in that cycle.
- Deskew stage:
  - Column j's valid and data pass through a shift register of NUM_COL-1-j stages. Column NUM_COL-1 has no delay.
  - The shift registers advance every cycle, unconditionally.
  - aligned_valid = AND of all delayed valids.
  - If the delayed valids are a mix of 0s and 1s, skew_err sets and stays set until clear or reset; that row is not pushed.
- Latency: column 0 sample at cycle t, with column j sampled at t+j → row pushed at the edge ending cycle t+NUM_COL-1 → out_valid high in cycle t+NUM_COL if the FIFO was empty.
- Row FIFO:
  - FIFO_DEPTH entries, circular read/write pointers, occupancy count 0..FIFO_DEPTH.
  - out_valid = (count != 0). out_data and out_last come from the head entry.
  - Pop on out_valid && out_ready.
  - Push on aligned_valid.
  - Push while full with a same-cycle pop: both happen and count is unchanged.
  - Push while full with no pop: row dropped, overflow_err sets (sticky), count unchanged.
  - Pointers wrap from FIFO_DEPTH-1 to 0.
  - out_data stays stable while out_valid && !out_ready.
- array_hold = (count >= FIFO_DEPTH - NUM_COL), decoded from the registered count. This reserves room for the rows still in flight in the skew pipeline.
- Row counter and out_last:
  - On push, the entry is tagged last when push_idx == rows_total-1.
  - push_idx increments per push; it returns to 0 after the last row is pushed.
  - With rows_total = 0, no entry is tagged last and done never pulses.
- done: registered; high for exactly one cycle after the pop of an entry tagged last.
- Error recovery: errors do not stop operation. Later valid rows are still collected.
- Async reset mid-stream discards rows in the deskew pipeline and FIFO. No partial row is emitted after reset deassertion.

Test Plan:
- Single-row wavefront (NUM_COL=4): col_valid bit j pulses at cycle 10+j with col_psum column j = 0x100+j, out_ready=1 → out_valid high only in cycle 14, out_data = {0x103,0x102,0x101,0x100}.
- Backpressure: rows_total=6, streaming rows 0..5 (column 0 of row k = k), out_ready=0.
  - array_hold rises when count reaches 4.
  - All 6 rows stored in order.
  - Then out_ready=1 drains rows 0..5 in order, with out_last on row 5 and done pulsing once in the cycle after row 5 pops.
- Full with simultaneous pop: fill 8 rows, then push a 9th in the same cycle out_ready=1 → count stays 8, overflow_err=0, 9th row emerges in order. Same push with out_ready=0 → row dropped, overflow_err=1.
- Skew error: column 2 valid pulses one cycle late → skew_err=1, no row pushed. The following correct wavefront is still emitted.
- Reset and clear mid-operation:
  - Assert rst_n=0 asynchronously between edges with 3 rows buffered and 1 row in the skew pipeline → all outputs 0 immediately, no rows emitted afterwards.
  - clear=1 for one cycle with rows buffered and skew_err=1 → all outputs 0 (FIFO empty, skew_err cleared) at the next edge.
